// File: rtl/rr_req_arbiter_if.sv
// rr_req_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_req_arbiter_if #(parameter int N = 8);
  logic [N-1:0] req;
  logic         gnt_ack;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         timeout_p;
  modport master (output req, gnt_ack, input gnt, gnt_valid, timeout_p);
  modport slave  (input req, gnt_ack, output gnt, gnt_valid, timeout_p);
endinterface

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter with held one-hot grant, ack/withdraw/timeout release
module rr_req_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_req_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state, state_n;
  logic [N-1:0]     gnt, gnt_n, others;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0]    ptr, ptr_n, gi, gi_next;
  logic             to_p, to_n, held, to_hit, rel;
  // Lowest rotation offset from p wins; the downward scan lets it overwrite higher offsets.
  function automatic logic [N-1:0] pick(input logic [N-1:0] m, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(p) + k) % N);
      if (m[idx]) pick = N'(1) << idx;
    end
  endfunction
  always_comb begin
    gi = '0;
    for (int k = 0; k < N; k++)
      if (gnt[k]) gi = IW'(k);
  end
  assign gi_next = (gi == IW'(N - 1)) ? '0 : gi + 1'b1;
  assign held    = |(bus.req & gnt);
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign rel     = bus.gnt_ack | ~held | to_hit;
  assign others  = bus.req & ~gnt;
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = (&cnt) ? cnt : cnt + 1'b1;
    ptr_n   = ptr;
    to_n    = 1'b0;
    if (state == IDLE) begin
      gnt_n   = |bus.req ? pick(bus.req, ptr) : '0;
      cnt_n   = '0;
      state_n = |bus.req ? GRANT : IDLE;
    end else if (rel) begin
      ptr_n   = gi_next;
      gnt_n   = |others ? pick(others, gi_next) : '0;
      cnt_n   = '0;
      state_n = |others ? GRANT : IDLE;
      to_n    = to_hit & ~bus.gnt_ack & held;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= '0;
      to_p  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      to_p  <= to_n;
    end
  assign bus.gnt       = gnt;
  assign bus.gnt_valid = |gnt;
  assign bus.timeout_p = to_p;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed vectors for the round-robin arbiter, untimed and TIMEOUT=4 instances
module tb_rr_req_arbiter;
  logic clk = 0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  rr_req_arbiter_if #(.N(8)) a ();
  rr_req_arbiter_if #(.N(8)) b ();
  rr_req_arbiter #(.N(8), .TIMEOUT(0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(a));
  rr_req_arbiter #(.N(8), .TIMEOUT(4), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %0h exp %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0;
    a.req = 8'hFF;
    a.gnt_ack = 0;
    b.req = 8'h00;
    b.gnt_ack = 0;
    repeat (2) tick();
    chk("rst_gnt", a.gnt, 0);
    chk("rst_valid", a.gnt_valid, 0);
    chk("rst_to", a.timeout_p, 0);
    rst_n = 1;
    tick();
    chk("first_gnt", a.gnt, 8'h01);
    chk("first_valid", a.gnt_valid, 1);
    a.gnt_ack = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rot%0d", i), a.gnt, 32'(8'h01 << (i % 8)));
    end
    a.gnt_ack = 0;
    a.req = 8'h04;
    tick();
    chk("hold0", a.gnt, 8'h04);
    tick();
    chk("hold1", a.gnt, 8'h04);
    tick();
    chk("hold2", a.gnt, 8'h04);
    a.gnt_ack = 1;
    tick();
    chk("ack_gap", a.gnt, 8'h00);
    chk("ack_gap_valid", a.gnt_valid, 0);
    a.gnt_ack = 0;
    tick();
    chk("regrant", a.gnt, 8'h04);
    a.req = 8'h00;
    tick();
    chk("withdraw", a.gnt, 8'h00);
    a.req = 8'h84;
    tick();
    chk("ptr3_first", a.gnt, 8'h80);
    a.gnt_ack = 1;
    tick();
    chk("ptr3_second", a.gnt, 8'h04);
    a.gnt_ack = 0;
    a.req = 8'hF4;
    tick();
    chk("other_req_stable", a.gnt, 8'h04);
    chk("no_to_untimed", a.timeout_p, 0);
    a.req = 8'h20;
    tick();
    chk("b2b_20", a.gnt, 8'h20);
    #2 rst_n = 0;
    #1;
    chk("async_rst_gnt", a.gnt, 0);
    chk("async_rst_valid", a.gnt_valid, 0);
    tick();
    rst_n = 1;
    a.gnt_ack = 1;
    a.req = 8'h00;
    tick();
    chk("ack_after_rst", a.gnt, 0);
    a.gnt_ack = 0;
    b.req = 8'h18;
    tick();
    chk("to_gnt0", b.gnt, 8'h08);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), b.gnt, 8'h08);
      chk($sformatf("to_nop%0d", i), b.timeout_p, 0);
    end
    tick();
    chk("to_next", b.gnt, 8'h10);
    chk("to_pulse", b.timeout_p, 1);
    tick();
    chk("to_pulse_end", b.timeout_p, 0);
    chk("to_next_hold", b.gnt, 8'h10);
    tick();
    tick();
    b.gnt_ack = 1;
    tick();
    chk("ack_prec_gnt", b.gnt, 8'h08);
    chk("ack_prec_to", b.timeout_p, 0);
    b.gnt_ack = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
